// File: rtl/afpm_pkg.sv
// afpm_pkg: shared constants for the FP16 logarithmic (Mitchell) multiplier.
//   FP16 field widths, the bias constant, special-value codes and the
//   9-phase frame encoding used by the byte-serial top level.
package afpm_pkg;

   localparam int FP_EXP_W = 5;
   localparam int FP_MAN_W = 10;

   // Exponent field position within a 16-bit FP16 word
   localparam int EXP_LSB = FP_MAN_W;
   localparam int EXP_MSB = FP_MAN_W + FP_EXP_W - 1;

   localparam logic [FP_EXP_W-1:0] EXP_ZERO = '0;
   localparam logic [FP_EXP_W-1:0] EXP_MAX  = '1;

   // Bias re-centring term for the log-domain sum (1.0 in FP16)
   localparam logic [15:0] BIAS     = 16'h3C00;
   localparam logic [15:0] FP_NAN   = 16'h7E00;
   localparam logic [14:0] FP_INF   = 15'h7C00;
   localparam logic [14:0] FP_ZERO  = 15'h0000;
   // Largest S that still lands in the subnormal range
   localparam logic [16:0] UFL_LIM  = 17'h003FF;

   // Frame phases: operand bytes in, multiply, result bytes out
   typedef enum logic [3:0] {
      PH_LO0  = 4'd0,
      PH_LO1  = 4'd1,
      PH_HI0  = 4'd2,
      PH_HI1  = 4'd3,
      PH_MUL  = 4'd4,
      PH_RLO0 = 4'd5,
      PH_RLO1 = 4'd6,
      PH_RHI0 = 4'd7,
      PH_RHI1 = 4'd8
   } phase_t;

endpackage

// File: rtl/afpm_mitchell_mul16.sv
// afpm_mitchell_mul16: combinational FP16 multiplier using Mitchell's
// logarithmic approximation. The FP16 magnitude bits are treated as a
// fixed-point log2, so adding them (minus the bias) approximates the
// product. No rounding; the mantissa is the truncated sum.
//   a, b : FP16 operands
//   p    : FP16 approximate product
module afpm_mitchell_mul16
   import afpm_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] p
);

   logic [FP_EXP_W-1:0] ea, eb;
   logic                sgn;
   logic signed [16:0]  s;

   assign ea  = a[EXP_MSB:EXP_LSB];
   assign eb  = b[EXP_MSB:EXP_LSB];
   assign sgn = a[15] ^ b[15];
   assign s   = $signed({2'b00, a[14:0]} + {2'b00, b[14:0]} - {1'b0, BIAS});

   always_comb begin
      p = {sgn, FP_ZERO};
      // inf * zero/subnormal is undefined: quiet NaN, sign dropped
      if ((ea == EXP_MAX && eb == EXP_ZERO) || (eb == EXP_MAX && ea == EXP_ZERO))
         p = FP_NAN;
      else if (ea == EXP_MAX || eb == EXP_MAX)
         p = {sgn, FP_INF};
      else if (ea == EXP_ZERO || eb == EXP_ZERO)
         p = {sgn, FP_ZERO};
      else if (s <= $signed(UFL_LIM))
         p = {sgn, FP_ZERO};
      else if (s >= $signed({2'b00, FP_INF}))
         p = {sgn, FP_INF};
      else
         p = {sgn, s[14:0]};
   end

endmodule

// File: rtl/tt_um_logarithmic_afpm.sv
// tt_um_logarithmic_afpm: byte-serial FP16 Mitchell multiplier.
// A free-running 9-phase frame moves operands in low byte first (each byte
// held 2 cycles), multiplies in phase 4, then streams the result out low
// byte first.
//   clk, rst : clock, synchronous active-high reset
//   ena      : design-select flag (unused)
//   ui_in    : operand A byte
//   uio_in   : operand B byte
//   uo_out   : registered result byte (0 outside result phases)
//   uio_out, uio_oe : tied to 0 (uio pins are inputs)
module tt_um_logarithmic_afpm
   import afpm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   phase_t      phase, phase_nxt;
   logic [15:0] a_q, b_q, r_q, r_nxt, prod;
   logic [7:0]  out_nxt;
   logic        unused_ok;

   assign uio_out   = 8'h00;
   assign uio_oe    = 8'h00;
   assign unused_ok = &{1'b0, ena};

   afpm_mitchell_mul16 u_mul (
      .a (a_q),
      .b (b_q),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) phase <= PH_LO0;
      else     phase <= phase_nxt;
   end

   // Output byte is registered against the upcoming phase; R's next value
   // is used so the low byte is already valid on the first result cycle.
   always_comb begin
      phase_nxt = (phase == PH_RHI1) ? PH_LO0 : phase_t'(phase + 4'd1);
      r_nxt     = (phase == PH_MUL) ? prod : r_q;
      out_nxt   = 8'h00;
      case (phase_nxt)
         PH_RLO0, PH_RLO1: out_nxt = r_nxt[7:0];
         PH_RHI0, PH_RHI1: out_nxt = r_nxt[15:8];
         default:          out_nxt = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         uo_out <= '0;
      end else begin
         if (phase == PH_LO1) begin
            a_q[7:0] <= ui_in;
            b_q[7:0] <= uio_in;
         end
         if (phase == PH_HI1) begin
            a_q[15:8] <= ui_in;
            b_q[15:8] <= uio_in;
         end
         r_q    <= r_nxt;
         uo_out <= out_nxt;
      end
   end

endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
// tb_tt_um_logarithmic_afpm: directed-vector bench for the byte-serial
// FP16 Mitchell multiplier. Expected results are hand-computed.
module tb_tt_um_logarithmic_afpm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int n_chk  = 0;
   int n_pass = 0;

   tt_um_logarithmic_afpm dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %04h expected %04h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered #1 after the edge that starts phase 0; leaves at the same
   // point of the following frame.
   task automatic run_frame(input string tag, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] r);
      ui_in  = a[7:0];
      uio_in = b[7:0];
      tick(); tick();                        // phase 2
      ui_in  = a[15:8];
      uio_in = b[15:8];
      tick(); tick();                        // phase 4
      chk({tag, ".ph4"}, {8'h00, uo_out}, 16'h0000);
      tick(); chk({tag, ".ph5"}, {8'h00, uo_out}, {8'h00, r[7:0]});
      tick(); chk({tag, ".ph6"}, {8'h00, uo_out}, {8'h00, r[7:0]});
      tick(); chk({tag, ".ph7"}, {8'h00, uo_out}, {8'h00, r[15:8]});
      tick(); chk({tag, ".ph8"}, {8'h00, uo_out}, {8'h00, r[15:8]});
      tick();                                // phase 0
   endtask

   initial begin
      rst = 1'b1;
      tick(); tick();
      chk("rst.uo",  {8'h00, uo_out},  16'h0000);
      chk("rst.uio", {uio_oe, uio_out}, 16'h0000);
      rst = 1'b0;                            // current cycle is phase 0

      run_frame("zero",    16'h0000, 16'h0000, 16'h0000);
      run_frame("1p5x3",   16'h3E00, 16'h4200, 16'h4400);
      run_frame("neg1x2",  16'hBC00, 16'h4000, 16'hC000);
      run_frame("1x1",     16'h3C00, 16'h3C00, 16'h3C00);
      run_frame("ovf",     16'h7BFF, 16'h7BFF, 16'h7C00);
      run_frame("infx0",   16'h7C00, 16'h0000, 16'h7E00);
      run_frame("ufl",     16'h0400, 16'h0400, 16'h0000);
      run_frame("infxneg", 16'h7C00, 16'hBC00, 16'hFC00);
      run_frame("negzero", 16'h0000, 16'hC000, 16'h8000);
      run_frame("n2xn2",   16'hC000, 16'hC000, 16'h4400);

      // Mid-frame reset: 2.0 x 2.0 aborted in phase 6
      ui_in = 8'h00; uio_in = 8'h00;
      tick(); tick();
      ui_in = 8'h40; uio_in = 8'h40;
      tick(); tick(); tick(); tick();        // phase 6
      chk("abort.ph6", {8'h00, uo_out}, 16'h0000);
      rst = 1'b1;
      tick();
      chk("abort.uo",  {8'h00, uo_out},   16'h0000);
      chk("abort.uio", {uio_oe, uio_out}, 16'h0000);
      rst = 1'b0;                            // restarts at phase 0
      run_frame("restart", 16'hBC00, 16'h3C00, 16'hBC00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tt_um_logarithmic_afpm.md
TT_UM_LOGARITHMIC_AFPM -- requirements
Module: tt_um_logarithmic_afpm

Interface
REQ-001 SHALL have no parameters (FP16 format fixed: 1 sign, 5 exponent, 10 mantissa, bias 15).
REQ-002 SHALL have port `clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port `ena`, input, 1 bit: design-selected flag; ignored.
REQ-005 SHALL have port `ui_in`, input, 8 bits: operand A byte.
REQ-006 SHALL have port `uio_in`, input, 8 bits: operand B byte.
REQ-007 SHALL have port `uo_out`, output, 8 bits: registered result byte.
REQ-008 SHALL have port `uio_out`, output, 8 bits: tied to 0.
REQ-009 SHALL have port `uio_oe`, output, 8 bits: tied to 0, so all uio pins are inputs.

Function
REQ-010 SHALL run a free-running 9-phase counter `phase` 0..8 that increments every clock and wraps 8->0; each phase is one clock cycle.
REQ-011 SHALL transfer operands byte-serially, low byte first; each byte is held for 2 cycles.
REQ-012 SHALL capture A[7:0]=ui_in and B[7:0]=uio_in at the end of phase 1.
REQ-013 SHALL capture A[15:8]=ui_in and B[15:8]=uio_in at the end of phase 3.
REQ-014 SHALL compute the product in phase 4 and load it into a 16-bit result register R at the end of phase 4.
REQ-015 SHALL set uo_out=R[7:0] in phases 5-6, uo_out=R[15:8] in phases 7-8, and uo_out=0 in phases 0-4 (registered).
REQ-016 SHALL make the latency from the first byte to the first result byte 5 cycles; the whole frame is 9 cycles and frames repeat back-to-back.
REQ-017 SHALL use Mitchell logarithmic multiplication on the magnitude bits: S = {0,A[14:0]} + {0,B[14:0]} - 0x3C00, evaluated in signed 17-bit arithmetic.
REQ-018 SHALL set the result sign to A[15] XOR B[15].
REQ-019 SHALL apply these special cases, in priority order:
  a) either exponent is 31 and the other operand's exponent is 0 -> R=0x7E00 (NaN).
  b) either exponent is 31 -> inf with the computed sign (0x7C00 or 0xFC00).
  c) either exponent is 0 (zero or subnormal) -> signed zero.
  d) S <= 0x03FF (underflow) -> signed zero.
  e) S >= 0x7C00 (overflow) -> signed inf.
  f) otherwise R = {sign, S[14:0]}.
REQ-020 SHALL NOT round; the mantissa is the truncated log-domain sum.
REQ-021 SHALL leave the operands and R unchanged outside their capture phases.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, set phase=0, A=0, B=0, R=0 and uo_out=0.
REQ-023 SHALL treat a reset asserted mid-frame as aborting the frame; the first cycle after release is phase 0.
REQ-024 SHALL hold uio_out and uio_oe at 0 at all times, including during reset.

Structure
REQ-025 SHALL place the FP16 field widths, the bias constant 0x3C00, the NaN/inf/zero codes and the phase encodings in a shared package afpm_pkg.
REQ-026 SHALL implement the combinational multiplier as a single sub-module afpm_mitchell_mul16 (inputs a[15:0], b[15:0]; output p[15:0]); the top level holds the phase counter, operand registers and output mux.

Verification
REQ-027 SHALL cover: A=0x0000, B=0x0000 -> uo_out=0x00 in phases 5-6 and 0x00 in phases 7-8.
REQ-028 SHALL cover: A=0x3E00 (1.5), B=0x4200 (3.0) -> R=0x4400 (4.0, Mitchell approximation); uo_out=0x00 then 0x44.
REQ-029 SHALL cover: A=0xBC00, B=0x4000 -> R=0xC000; A=0x3C00, B=0x3C00 -> R=0x3C00.
REQ-030 SHALL cover: A=0x7BFF, B=0x7BFF -> R=0x7C00; A=0x7C00, B=0x0000 -> R=0x7E00.
REQ-031 SHALL cover: A=0x0400, B=0x0400 -> R=0x0000 (underflow).
REQ-032 SHALL cover: rst asserted during phase 6 -> uo_out=0 on the next cycle and the frame restarts at phase 0 after release.
